// File: rtl/fluid_payment_dispense.sv
// Payment and dispense stage: collects coin credit for one priced order, runs the valve
// one litre per FLOW_CYCLES, then settles with a one-cycle done pulse carrying change or refund.
module fluid_payment_dispense #(
    parameter int FLOW_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        order_valid,
    output logic        order_ready,
    input  logic [1:0]  order_fluid,
    input  logic [7:0]  order_volume,
    input  logic [15:0] order_price,
    input  logic        order_restock,
    input  logic        coin_valid,
    input  logic [7:0]  coin_value,
    output logic        coin_ready,
    input  logic        cancel,
    output logic        valve_open,
    output logic [1:0]  valve_sel,
    output logic [7:0]  liters_done,
    output logic        done,
    output logic        change_valid,
    output logic [15:0] change_amount,
    output logic [1:0]  status
);

    localparam int FW = (FLOW_CYCLES > 1) ? $clog2(FLOW_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLOW_LAST   = FW'(FLOW_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAY,
        S_DISPENSE,
        S_SETTLE
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_REFUSED = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_CANCEL  = 2'b11
    } status_t;

    state_t        state_q,  state_d;
    status_t       status_q, status_d;
    logic [1:0]    fluid_q,  fluid_d;
    logic [7:0]    volume_q, volume_d;
    logic [15:0]   price_q,  price_d;
    logic [15:0]   credit_q, credit_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic [FW-1:0] flow_q,   flow_d;
    logic [7:0]    liters_q, liters_d;
    logic [15:0]   change_q, change_d;

    logic [16:0]   credit_sum;
    logic [15:0]   coin_credit;

    // Credit after this cycle's coin, saturating so a long run of coins never wraps to a small value.
    assign credit_sum  = {1'b0, credit_q} + {9'b0, coin_value};
    assign coin_credit = !coin_valid    ? credit_q :
                         credit_sum[16] ? 16'hFFFF : credit_sum[15:0];

    // NOTE: every next-state variable takes its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        fluid_d  = fluid_q;
        volume_d = volume_q;
        price_d  = price_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        flow_d   = flow_q;
        liters_d = liters_q;
        change_d = change_q;

        case (state_q)
            S_IDLE: begin
                if (order_valid) begin
                    fluid_d  = order_fluid;
                    volume_d = order_volume;
                    price_d  = order_price;
                    credit_d = '0;
                    timer_d  = '0;
                    flow_d   = '0;
                    liters_d = '0;
                    if (order_restock || order_volume == 8'd0) begin
                        state_d  = S_SETTLE;
                        status_d = ST_REFUSED;
                        change_d = '0;
                    end else begin
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                credit_d = coin_credit;
                timer_d  = coin_valid ? '0 : timer_q + TW'(1);
                if (cancel) begin
                    state_d  = S_SETTLE;
                    status_d = ST_CANCEL;
                    change_d = coin_credit;
                end else if (credit_q >= price_q) begin
                    state_d = S_DISPENSE;
                    flow_d  = '0;
                end else if (!coin_valid && (timer_q + TW'(1)) == TIMEOUT_MAX) begin
                    state_d  = S_SETTLE;
                    status_d = ST_TIMEOUT;
                    change_d = credit_q;
                end
            end
            S_DISPENSE: begin
                if (flow_q == FLOW_LAST) begin
                    flow_d   = '0;
                    liters_d = liters_q + 8'd1;
                    if (liters_q + 8'd1 == volume_q) begin
                        state_d  = S_SETTLE;
                        status_d = ST_OK;
                        change_d = credit_q - price_q;
                    end
                end else begin
                    flow_d = flow_q + FW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            fluid_q  <= '0;
            volume_q <= '0;
            price_q  <= '0;
            credit_q <= '0;
            timer_q  <= '0;
            flow_q   <= '0;
            liters_q <= '0;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            fluid_q  <= fluid_d;
            volume_q <= volume_d;
            price_q  <= price_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            flow_q   <= flow_d;
            liters_q <= liters_d;
            change_q <= change_d;
        end
    end

    // Outputs decode from state so a reset closes the valve without waiting for a clock edge.
    assign order_ready   = (state_q == S_IDLE);
    assign coin_ready    = (state_q == S_PAY);
    assign valve_open    = (state_q == S_DISPENSE);
    assign valve_sel     = (state_q == S_DISPENSE) ? fluid_q : 2'b00;
    assign done          = (state_q == S_SETTLE);
    assign change_valid  = (state_q == S_SETTLE);
    assign change_amount = (state_q == S_SETTLE) ? change_q : 16'd0;
    assign liters_done   = liters_q;
    assign status        = status_q;

endmodule

// File: tb/tb_fluid_payment_dispense.sv
// Bench for fluid_payment_dispense: a cycle model built from order totals (credit, coin-free count,
// elapsed valve cycles) is compared every cycle, plus hand-computed per-order expectations.
module tb_fluid_payment_dispense;

    localparam int FLOW = 4;
    localparam int TMO  = 64;

    localparam int P_IDLE   = 0;
    localparam int P_PAY    = 1;
    localparam int P_DISP   = 2;
    localparam int P_SETTLE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        order_valid = 1'b0;
    logic        order_ready;
    logic [1:0]  order_fluid = '0;
    logic [7:0]  order_volume = '0;
    logic [15:0] order_price = '0;
    logic        order_restock = 1'b0;
    logic        coin_valid = 1'b0;
    logic [7:0]  coin_value = '0;
    logic        coin_ready;
    logic        cancel = 1'b0;
    logic        valve_open;
    logic [1:0]  valve_sel;
    logic [7:0]  liters_done;
    logic        done;
    logic        change_valid;
    logic [15:0] change_amount;
    logic [1:0]  status;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fluid_payment_dispense #(
        .FLOW_CYCLES   (FLOW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .order_valid  (order_valid),
        .order_ready  (order_ready),
        .order_fluid  (order_fluid),
        .order_volume (order_volume),
        .order_price  (order_price),
        .order_restock(order_restock),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .coin_ready   (coin_ready),
        .cancel       (cancel),
        .valve_open   (valve_open),
        .valve_sel    (valve_sel),
        .liters_done  (liters_done),
        .done         (done),
        .change_valid (change_valid),
        .change_amount(change_amount),
        .status       (status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: order phase plus running totals.
    int m_phase   = P_IDLE;
    int m_fluid   = 0;
    int m_vol     = 0;
    int m_price   = 0;
    int m_credit  = 0;
    int m_idle    = 0;
    int m_elapsed = 0;
    int m_change  = 0;
    int m_status  = 0;

    always @(posedge clk or posedge reset) begin : model
        int c, ni, ne;
        if (reset) begin
            m_phase   <= P_IDLE;
            m_fluid   <= 0;
            m_vol     <= 0;
            m_price   <= 0;
            m_credit  <= 0;
            m_idle    <= 0;
            m_elapsed <= 0;
            m_change  <= 0;
            m_status  <= 0;
        end else begin
            case (m_phase)
                P_IDLE: if (order_valid) begin
                    m_fluid   <= int'(order_fluid);
                    m_vol     <= int'(order_volume);
                    m_price   <= int'(order_price);
                    m_credit  <= 0;
                    m_idle    <= 0;
                    m_elapsed <= 0;
                    if (order_restock || order_volume == 0) begin
                        m_phase  <= P_SETTLE;
                        m_status <= 1;
                        m_change <= 0;
                    end else begin
                        m_phase <= P_PAY;
                    end
                end
                P_PAY: begin
                    c  = coin_valid ? m_credit + int'(coin_value) : m_credit;
                    if (c > 65535) c = 65535;
                    ni = coin_valid ? 0 : m_idle + 1;
                    m_credit <= c;
                    m_idle   <= ni;
                    if (cancel) begin
                        m_phase  <= P_SETTLE;
                        m_status <= 3;
                        m_change <= c;
                    end else if (m_credit >= m_price) begin
                        m_phase <= P_DISP;
                    end else if (ni >= TMO) begin
                        m_phase  <= P_SETTLE;
                        m_status <= 2;
                        m_change <= m_credit;
                    end
                end
                P_DISP: begin
                    ne = m_elapsed + 1;
                    m_elapsed <= ne;
                    if (ne == m_vol * FLOW) begin
                        m_phase  <= P_SETTLE;
                        m_status <= 0;
                        m_change <= m_credit - m_price;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("order_ready",   order_ready,   m_phase == P_IDLE);
        check("coin_ready",    coin_ready,    m_phase == P_PAY);
        check("valve_open",    valve_open,    m_phase == P_DISP);
        check("valve_sel",     valve_sel,     (m_phase == P_DISP) ? m_fluid : 0);
        check("liters_done",   liters_done,   m_elapsed / FLOW);
        check("done",          done,          m_phase == P_SETTLE);
        check("change_valid",  change_valid,  m_phase == P_SETTLE);
        check("change_amount", change_amount, (m_phase == P_SETTLE) ? m_change : 0);
        check("status",        status,        m_status);
    end

    // Stimulus tasks start and end at a falling edge.
    task automatic idle();
        order_valid = 1'b0;
        coin_valid  = 1'b0;
        cancel      = 1'b0;
        @(negedge clk);
    endtask

    task automatic offer(input logic [1:0] f, input logic [7:0] v, input logic [15:0] p,
                         input logic r, input int hold);
        order_valid   = 1'b1;
        order_fluid   = f;
        order_volume  = v;
        order_price   = p;
        order_restock = r;
        repeat (hold) @(negedge clk);
        order_valid   = 1'b0;
        order_restock = 1'b0;
    endtask

    task automatic coin(input logic [7:0] val, input logic canc);
        coin_valid = 1'b1;
        coin_value = val;
        cancel     = canc;
        @(negedge clk);
        coin_valid = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic expect_settle(input string tag, input int budget, input int exp_cycles,
                                 input int exp_valves, input int exp_sel, input int exp_chg,
                                 input int exp_st, input int exp_lit);
        int cycles, valves, sel_seen, chg, st, lit;
        bit found;
        cycles = 0; valves = 0; sel_seen = 0; chg = -1; st = -1; lit = -1; found = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                found = 1;
                chg   = int'(change_amount);
                st    = int'(status);
                lit   = int'(liters_done);
                break;
            end
            if (valve_open) begin
                valves++;
                sel_seen = int'(valve_sel);
            end
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, found, 1);
        check({tag, "_latency"}, cycles, exp_cycles);
        check({tag, "_valve_cycles"}, valves, exp_valves);
        check({tag, "_valve_sel"}, sel_seen, exp_sel);
        check({tag, "_change"}, chg, exp_chg);
        check({tag, "_status"}, st, exp_st);
        check({tag, "_liters"}, lit, exp_lit);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_order_ready", order_ready, 1);
        check("rst_valve_open", valve_open, 0);
        check("rst_status", status, 0);
        check("rst_change", change_amount, 0);

        // Exact pay: 2 litres of water for 20, coins 10 + 10.
        offer(2'b00, 8'd2, 16'd20, 1'b0, 1);
        coin(8'd10, 1'b0);
        coin(8'd10, 1'b0);
        expect_settle("exact", 40, 9, 8, 0, 0, 0, 2);

        // Overpay, with the order offered during the done cycle and held one more cycle.
        check("ready_in_done", order_ready, 0);
        offer(2'b01, 8'd1, 16'd15, 1'b0, 1);
        check("ready_after_done", order_ready, 1);
        offer(2'b01, 8'd1, 16'd15, 1'b0, 1);
        coin(8'd20, 1'b0);
        expect_settle("overpay", 40, 5, 4, 1, 5, 0, 1);
        idle();

        // Restock refusal settles the cycle after acceptance.
        offer(2'b10, 8'd3, 16'd50, 1'b1, 1);
        expect_settle("restock", 10, 0, 0, 0, 0, 1, 0);
        idle();

        // Timeout: one coin of 10, then 64 coin-free cycles.
        offer(2'b00, 8'd1, 16'd30, 1'b0, 1);
        coin(8'd10, 1'b0);
        expect_settle("timeout", 200, 64, 0, 0, 10, 2, 0);
        check("late_coin_ready", coin_ready, 0);
        coin(8'd50, 1'b0);
        check("idle_coin_ready", coin_ready, 0);
        check("status_held", status, 2);

        // Cancel with a coin in the same cycle refunds both coins.
        offer(2'b00, 8'd2, 16'd40, 1'b0, 1);
        coin(8'd10, 1'b0);
        idle();
        coin(8'd5, 1'b1);
        expect_settle("cancel", 10, 0, 0, 0, 15, 3, 0);
        idle();

        // Free order of 3 litres, reset after the first litre.
        offer(2'b10, 8'd3, 16'd0, 1'b0, 1);
        check("free_pay_cycle", coin_ready, 1);
        idle();
        check("free_valve_t2", valve_open, 1);
        check("free_sel_t2", valve_sel, 2);
        begin
            bit reached;
            reached = 0;
            for (int i = 0; i < 20; i++) begin
                if (liters_done == 8'd1) begin
                    reached = 1;
                    break;
                end
                @(negedge clk);
            end
            check("litre1_reached", reached, 1);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_valve", valve_open, 0);
        check("midrst_done", done, 0);
        check("midrst_liters", liters_done, 0);
        #1 reset = 1'b0;
        #1;
        check("midrst_ready", order_ready, 1);
        @(negedge clk);

        // Free single litre after reset, then a zero-volume refusal.
        offer(2'b01, 8'd1, 16'd0, 1'b0, 1);
        expect_settle("free1", 20, 5, 4, 1, 0, 0, 1);
        idle();
        offer(2'b00, 8'd0, 16'd10, 1'b0, 1);
        expect_settle("zerovol", 10, 0, 0, 0, 0, 1, 0);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
